rv32_data_memory_responder: RTL and testbench

// - Memory-side responder for the memory stage data port: byte-enabled stores, one-cycle-latency loads.
// - Backs a word-addressed data RAM plus a small MMIO window (64-bit cycle timer, tohost, scratch).
// - Consumes lane-aligned byte enables/data from the memory controller; returns raw 32-bit words.

---
 rtl/rv32_pkg.sv | 29 ++
 rtl/rv32_byte_ram.sv | 29 ++
 rtl/rv32_data_memory_responder.sv | 129 ++++++++++++
 tb/tb_rv32_data_memory_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the RV32 data memory responder:
// address region tags, MMIO word offsets and a byte-lane merge helper.
package rv32_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

  localparam logic [1:0] MMIO_MTIME_LO = 2'd0;
  localparam logic [1:0] MMIO_MTIME_HI = 2'd1;
  localparam logic [1:0] MMIO_TOHOST   = 2'd2;
  localparam logic [1:0] MMIO_SCRATCH  = 2'd3;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32_byte_ram.sv
// Word-wide synchronous RAM with per-byte write strobes.
// Read-first, registered output, array never reset.
module rv32_byte_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = "",
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32_data_memory_responder.sv
// Memory-stage data port responder: byte-enabled RAM plus an MMIO
// window holding a 64-bit cycle timer, tohost and a scratch register.
module rv32_data_memory_responder
  import rv32_pkg::*;
#(
  parameter logic [31:0] RAM_BASE    = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  write_enable_i,
  input  logic [31:0] data_address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
  output logic        error_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS) << 2;

  logic [31:0] ram_off;
  logic [1:0]  mmio_off;
  region_e     region_d;
  region_e     region_q;
  logic        any_we;
  logic        mmio_wr;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mmio_rd_d;
  logic [31:0] mmio_rd_q;
  logic [63:0] mtime_q;
  logic [31:0] shadow_q;
  logic [31:0] scratch_q;
  logic [31:0] tohost_data_q;
  logic        tohost_valid_q;
  logic        err_q;

  // Wrapping subtraction folds "below base" into the same range check.
  assign ram_off  = data_address_i - RAM_BASE;
  assign mmio_off = data_address_i[3:2];
  assign any_we   = |write_enable_i;

  always_comb begin
    region_d = REGION_NONE;
    if (ram_off < RAM_BYTES) begin
      region_d = REGION_RAM;
    end else if (data_address_i[31:4] == MMIO_BASE[31:4]) begin
      region_d = REGION_MMIO;
    end
  end

  assign mmio_wr = (region_d == REGION_MMIO) && any_we;
  assign ram_we  = (region_d == REGION_RAM && !rst_i)
                 ? write_enable_i : 4'b0000;

  rv32_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_off[AW+1:2]),
    .wdata_i(write_data_i),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    mmio_rd_d = '0;
    unique case (mmio_off)
      MMIO_MTIME_LO: mmio_rd_d = mtime_q[31:0];
      MMIO_MTIME_HI: mmio_rd_d = shadow_q;
      MMIO_TOHOST:   mmio_rd_d = '0;
      MMIO_SCRATCH:  mmio_rd_d = scratch_q;
      default:       mmio_rd_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      region_q       <= REGION_NONE;
      mmio_rd_q      <= '0;
      mtime_q        <= '0;
      shadow_q       <= '0;
      scratch_q      <= '0;
      tohost_data_q  <= '0;
      tohost_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      region_q       <= region_d;
      mmio_rd_q      <= mmio_rd_d;
      mtime_q        <= mtime_q + 64'd1;
      tohost_valid_q <= mmio_wr && (mmio_off == MMIO_TOHOST);
      // Low-half read snapshots the high half so a LO/HI pair never tears.
      if (region_d == REGION_MMIO && mmio_off == MMIO_MTIME_LO) begin
        shadow_q <= mtime_q[63:32];
      end
      if (mmio_wr && mmio_off == MMIO_TOHOST) begin
        tohost_data_q <= byte_merge(tohost_data_q, write_data_i,
                                    write_enable_i);
      end
      if (mmio_wr && mmio_off == MMIO_SCRATCH) begin
        scratch_q <= byte_merge(scratch_q, write_data_i,
                                write_enable_i);
      end
      if (region_d == REGION_NONE && any_we) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    read_data_o = '0;
    if (region_q == REGION_RAM) begin
      read_data_o = ram_rdata;
    end else if (region_q == REGION_MMIO) begin
      read_data_o = mmio_rd_q;
    end
  end

  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_rv32_data_memory_responder.sv
// Directed bench for rv32_data_memory_responder: RAM stores/loads,
// timer tear-freedom, tohost pulses, scratch, unmapped errors, reset.
module tb_rv32_data_memory_responder;

  logic        clk;
  logic        rst;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        th_valid;
  logic [31:0] th_data;
  logic        err;

  int checks;
  int failures;

  localparam logic [31:0] RAM0    = 32'h0001_0000;
  localparam logic [31:0] RAMLAST = 32'h0001_3FFC;
  localparam logic [31:0] M_LO    = 32'h8000_0000;
  localparam logic [31:0] M_HI    = 32'h8000_0004;
  localparam logic [31:0] M_TH    = 32'h8000_0008;
  localparam logic [31:0] M_SC    = 32'h8000_000C;

  rv32_data_memory_responder dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .write_enable_i(we),
    .data_address_i(addr),
    .write_data_i  (wdata),
    .read_data_o   (rdata),
    .tohost_valid_o(th_valid),
    .tohost_data_o (th_data),
    .error_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(4'h0, 32'h4000_0000, 32'h0);
    tick;
    tick;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_valid", {31'b0, th_valid}, 32'h0);
    chk("rst_thdata", th_data, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rst = 1'b0;

    drive(4'hF, RAM0, 32'hDEAD_BEEF);
    tick;
    drive(4'h0, RAM0, 32'h0);
    tick;
    chk("ram_word", rdata, 32'hDEAD_BEEF);

    drive(4'hF, RAM0 + 4, 32'h1122_3344);
    tick;
    drive(4'h1, RAM0 + 4, 32'h0000_00AA);
    tick;
    drive(4'h2, RAM0 + 4, 32'h0000_BB00);
    tick;
    drive(4'h0, RAM0 + 4, 32'h0);
    tick;
    chk("ram_bytes", rdata, 32'h1122_BBAA);

    drive(4'hF, RAM0 + 8, 32'h9);
    tick;
    drive(4'hF, RAM0 + 8, 32'h5);
    tick;
    chk("ram_rdfirst", rdata, 32'h9);
    drive(4'h0, RAM0 + 8 + 3, 32'h0);
    tick;
    chk("ram_after", rdata, 32'h5);

    drive(4'hF, RAMLAST, 32'hCAFE_F00D);
    tick;
    drive(4'h0, RAMLAST, 32'h0);
    tick;
    chk("ram_last", rdata, 32'hCAFE_F00D);
    drive(4'h0, RAMLAST + 4, 32'h0);
    tick;
    chk("past_end_rd", rdata, 32'h0);
    drive(4'h0, RAM0 - 4, 32'h0);
    tick;
    chk("below_rd", rdata, 32'h0);
    chk("load_noerr", {31'b0, err}, 32'h0);

    drive(4'h0, M_LO, 32'h0);
    force dut.mtime_q = 64'h0000_0001_FFFF_FFFF;
    #1;
    release dut.mtime_q;
    tick;
    chk("mtime_lo", rdata, 32'hFFFF_FFFF);
    drive(4'h0, M_HI, 32'h0);
    tick;
    chk("mtime_hi", rdata, 32'h0000_0001);
    drive(4'h0, M_LO, 32'h0);
    tick;
    chk("mtime_lo2", rdata, 32'h0000_0001);
    drive(4'h0, M_HI, 32'h0);
    tick;
    chk("mtime_hi2", rdata, 32'h0000_0002);

    drive(4'hF, M_TH, 32'h1);
    tick;
    chk("th_pulse", {31'b0, th_valid}, 32'h1);
    chk("th_data", th_data, 32'h1);
    drive(4'h0, M_TH, 32'h0);
    tick;
    chk("th_once", {31'b0, th_valid}, 32'h0);
    chk("th_rd0", rdata, 32'h0);
    drive(4'h2, M_TH, 32'h0000_AB00);
    tick;
    chk("th_b2b1", {31'b0, th_valid}, 32'h1);
    chk("th_merge1", th_data, 32'h0000_AB01);
    drive(4'h8, M_TH, 32'h7F00_0000);
    tick;
    chk("th_b2b2", {31'b0, th_valid}, 32'h1);
    chk("th_merge2", th_data, 32'h7F00_AB01);
    drive(4'h0, M_SC, 32'h0);
    tick;
    chk("th_end", {31'b0, th_valid}, 32'h0);

    drive(4'hF, M_SC, 32'h1234_5678);
    tick;
    drive(4'h4, M_SC, 32'h00AA_0000);
    tick;
    chk("sc_rdfirst", rdata, 32'h1234_5678);
    drive(4'h0, M_SC, 32'h0);
    tick;
    chk("sc_merge", rdata, 32'h12AA_5678);

    drive(4'hF, M_LO, 32'hFFFF_FFFF);
    tick;
    chk("mtime_wr_noerr", {31'b0, err}, 32'h0);

    drive(4'hF, 32'h4000_0000, 32'hFFFF_FFFF);
    tick;
    chk("unmap_rd", rdata, 32'h0);
    chk("unmap_err", {31'b0, err}, 32'h1);
    drive(4'h0, RAM0, 32'h0);
    tick;
    chk("err_sticky", {31'b0, err}, 32'h1);
    chk("unmap_drop", rdata, 32'hDEAD_BEEF);

    rst = 1'b1;
    drive(4'hF, RAM0, 32'h0BAD_F00D);
    tick;
    chk("rst2_rdata", rdata, 32'h0);
    chk("rst2_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    drive(4'h0, M_LO, 32'h0);
    tick;
    chk("mtime_rst0", rdata, 32'h0);
    tick;
    chk("mtime_rst1", rdata, 32'h1);
    drive(4'h0, RAM0, 32'h0);
    tick;
    chk("rst_store_drop", rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
